// File: rtl/oserdes_pkg.sv
// Shared definitions for the oserdes_4_to_1 transmit serializer.
//   oserdes_state_e   : FSM states (IDLE, TRAIN, DATA)
//   DEF_TRAIN_PATTERN : default training word (shown LSB-first as 1,1,0,0)
//   DEF_IDLE_WORD     : default word shifted out when DATA has nothing pending
//   clog2()           : bit-counter width helper
package oserdes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } oserdes_state_e;

  localparam logic [3:0] DEF_TRAIN_PATTERN = 4'b0011;
  localparam logic [3:0] DEF_IDLE_WORD     = 4'b0000;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/oserdes_4_to_1_piso_shift.sv
// Parallel-in serial-out shifter with bit counter for oserdes_4_to_1.
// Ports:
//   CLK, RST_N     clock, synchronous active-low reset
//   clr_i          clear shifter and bit counter (serializer idle)
//   force_load_i   load slot independent of bit counter (first TRAIN cycle)
//   word_i         word taken by the shifter at a load slot
//   load_slot_o    this cycle is a load slot
//   q_o            serial bit (shifter LSB, registered)
//   word_start_o   high in the cycle q_o carries bit 0 of a word
module oserdes_piso_shift
  import oserdes_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr_i,
  input  logic             force_load_i,
  input  logic [WIDTH-1:0] word_i,
  output logic             load_slot_o,
  output logic             q_o,
  output logic             word_start_o
);

  localparam int unsigned CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ws_q, ws_d;

  assign load_slot_o = force_load_i || (bit_cnt_q == CW'(WIDTH - 1));

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ws_d      = 1'b0;
    if (clr_i) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (load_slot_o) begin
      shift_d   = word_i;
      bit_cnt_d = '0;
      ws_d      = 1'b1;
    end else begin
      shift_d   = shift_q >> 1;
      bit_cnt_d = bit_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ws_q      <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ws_q      <= ws_d;
    end
  end

  assign q_o          = shift_q[0];
  assign word_start_o = ws_q;

endmodule

// File: rtl/oserdes_4_to_1.sv
// Fabric-side TX serializer: WIDTH-bit words in over valid/ready, shifted
// out LSB-first one bit per CLK. Sends TRAIN_WORDS training words after
// PLL lock, then data; inserts IDLE_WORD when no word is pending.
// Ports:
//   CLK, RST_N   clock, synchronous active-low reset
//   EN           transmit enable
//   PLL_LOCK     PLL lock; loss forces immediate return to IDLE
//   D, D_VALID   parallel word and its valid
//   D_READY      word is accepted this cycle when D_VALID is high
//   Q            serial data (registered)
//   Q_EN         output enable, high while Q carries train or data
//   WORD_START   Q carries bit 0 of a word
//   TRAIN_DONE   in DATA state
//   UNDERFLOW    sticky, set on idle-word insertion in DATA
//   UNDERFLOW_CNT  saturating insertion count (only with macro
//                  OSERDES_UNDERFLOW_CNT_EN defined)
module oserdes_4_to_1
  import oserdes_pkg::*;
#(
  parameter int unsigned      WIDTH         = 4,
  parameter int unsigned      TRAIN_WORDS   = 16,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(DEF_TRAIN_PATTERN),
  parameter logic [WIDTH-1:0] IDLE_WORD     = WIDTH'(DEF_IDLE_WORD)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             PLL_LOCK,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
  output logic             Q,
  output logic             Q_EN,
  output logic             WORD_START,
  output logic             TRAIN_DONE,
  output logic             UNDERFLOW
`ifdef OSERDES_UNDERFLOW_CNT_EN
  ,
  output logic [7:0]       UNDERFLOW_CNT
`endif
);

  oserdes_state_e   state_q, state_d;
  logic [7:0]       train_cnt_q, train_cnt_d;
  logic             first_q, first_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             q_en_q, q_en_d;
  logic             uf_q, uf_d;
  logic [WIDTH-1:0] word_d;
  logic             slot, clr, accept, ins_idle;

  assign D_READY = (state_q == ST_DATA) && (!hold_vld_q || slot);
  assign accept  = D_VALID && D_READY;
  // Serializer is held cleared while idle and on the edge that returns to idle.
  assign clr     = (state_q == ST_IDLE) || (state_d == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    first_d     = 1'b0;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    q_en_d      = q_en_q;
    uf_d        = uf_q;
    word_d      = IDLE_WORD;
    ins_idle    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (EN) begin
          state_d = ST_TRAIN;
          first_d = 1'b1;
        end
      end
      ST_TRAIN: begin
        if (slot) begin
          if (!EN) begin
            state_d = ST_IDLE;
          end else if (train_cnt_q == 8'(TRAIN_WORDS)) begin
            // Slot that enters DATA: nothing can be held yet (D_READY was low),
            // so IDLE_WORD goes out; not an underflow since state is still TRAIN.
            state_d = ST_DATA;
          end else begin
            word_d      = TRAIN_PATTERN;
            train_cnt_d = train_cnt_q + 8'd1;
          end
        end
      end
      ST_DATA: begin
        if (slot) begin
          if (!EN) begin
            state_d = ST_IDLE;
          end else if (hold_vld_q) begin
            word_d     = hold_q;
            hold_vld_d = 1'b0;
          end else begin
            ins_idle = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // New word may enter hold on the same edge the old one is loaded.
    if (accept) begin
      hold_d     = D;
      hold_vld_d = 1'b1;
    end
    if (!PLL_LOCK) state_d = ST_IDLE;
    if (state_d == ST_IDLE) begin
      hold_vld_d  = 1'b0;
      train_cnt_d = '0;
      q_en_d      = 1'b0;
      first_d     = 1'b0;
      ins_idle    = 1'b0;
    end else if (slot) begin
      q_en_d = 1'b1;
    end
    if (ins_idle) uf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      train_cnt_q <= '0;
      first_q     <= 1'b0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      q_en_q      <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      first_q     <= first_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      q_en_q      <= q_en_d;
      uf_q        <= uf_d;
    end
  end

  oserdes_piso_shift #(
    .WIDTH(WIDTH)
  ) u_piso (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .clr_i       (clr),
    .force_load_i(first_q),
    .word_i      (word_d),
    .load_slot_o (slot),
    .q_o         (Q),
    .word_start_o(WORD_START)
  );

  assign Q_EN       = q_en_q;
  assign TRAIN_DONE = (state_q == ST_DATA);
  assign UNDERFLOW  = uf_q;

`ifdef OSERDES_UNDERFLOW_CNT_EN
  logic [7:0] uf_cnt_q;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      uf_cnt_q <= '0;
    end else if (ins_idle && (uf_cnt_q != 8'hFF)) begin
      uf_cnt_q <= uf_cnt_q + 8'd1;
    end
  end
  assign UNDERFLOW_CNT = uf_cnt_q;
`endif

endmodule
